// File: rtl/disparity_search_engine.sv
// Block-matching disparity search controller: sweeps anchors and disparities,
// tracks the minimum block cost and emits one disparity result per pixel.
module disparity_search_engine #(
  parameter int IMG_W      = 240,
  parameter int IMG_H      = 320,
  parameter int BLOCK_SIZE = 6,
  parameter int MAX_DISP   = 64,
  parameter int COST_W     = 23,
  parameter int TIE_LAST   = 1,
  parameter int X_W        = $clog2(IMG_W),
  parameter int Y_W        = $clog2(IMG_H),
  parameter int DISP_W     = $clog2(MAX_DISP + 1),
  parameter int ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [COST_W-1:0] cost_thresh_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              req_valid_out,
  input  logic              req_ready_in,
  output logic [X_W-1:0]    req_x_out,
  output logic [Y_W-1:0]    req_y_out,
  output logic [DISP_W-1:0] req_d_out,
  input  logic              cost_valid_in,
  input  logic [COST_W-1:0] cost_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
  output logic [ADDR_W-1:0] res_addr_out,
  output logic [DISP_W-1:0] res_disp_out,
  output logic              res_conf_out
);

  localparam int XL = IMG_W - BLOCK_SIZE;
  localparam int YL = IMG_H - BLOCK_SIZE;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, RES, DONE
  } state_t;

  state_t            state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [DISP_W-1:0] d;
  logic [DISP_W-1:0] best_d;
  logic [COST_W-1:0] min_cost;
  logic [COST_W-1:0] thresh;

  logic [DISP_W-1:0] dmax;
  logic              last_d;
  logic              last_x;
  logic              last_y;
  logic              take;
  logic [COST_W-1:0] new_min;
  logic [DISP_W-1:0] new_best;
  logic [ADDR_W-1:0] addr;

  assign req_x_out = x;
  assign req_y_out = y;
  assign req_d_out = d;

  always_comb begin
    if (32'(x) > 32'(MAX_DISP)) begin
      dmax = DISP_W'(MAX_DISP);
    end else begin
      dmax = DISP_W'(x);
    end
    last_d = (d >= dmax);
    last_x = (32'(x) >= 32'(XL));
    last_y = (32'(y) >= 32'(YL));
    // d==0 always seeds; ties replace only in last-wins mode
    take = (d == '0)
        || (cost_in < min_cost)
        || ((TIE_LAST != 0) && (cost_in == min_cost));
    new_min  = take ? cost_in : min_cost;
    new_best = take ? d : best_d;
    addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      d             <= '0;
      best_d        <= '0;
      min_cost      <= '0;
      thresh        <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      req_valid_out <= 1'b0;
      res_valid_out <= 1'b0;
      res_addr_out  <= '0;
      res_disp_out  <= '0;
      res_conf_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (abort_in && (state != IDLE)) begin
        state         <= IDLE;
        busy_out      <= 1'b0;
        req_valid_out <= 1'b0;
        res_valid_out <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_in) begin
              thresh        <= cost_thresh_in;
              x             <= '0;
              y             <= '0;
              d             <= '0;
              busy_out      <= 1'b1;
              req_valid_out <= 1'b1;
              state         <= REQ;
            end
          end
          REQ: begin
            if (req_ready_in) begin
              req_valid_out <= 1'b0;
              state         <= WAIT;
            end
          end
          WAIT: begin
            if (cost_valid_in) begin
              min_cost <= new_min;
              best_d   <= new_best;
              if (!last_d) begin
                d             <= d + 1'b1;
                req_valid_out <= 1'b1;
                state         <= REQ;
              end else begin
                res_addr_out  <= addr;
                res_disp_out  <= new_best;
                res_conf_out  <= (new_min <= thresh);
                res_valid_out <= 1'b1;
                state         <= RES;
              end
            end
          end
          RES: begin
            if (res_ready_in) begin
              res_valid_out <= 1'b0;
              d             <= '0;
              if (!last_x) begin
                x             <= x + 1'b1;
                req_valid_out <= 1'b1;
                state         <= REQ;
              end else if (!last_y) begin
                x             <= '0;
                y             <= y + 1'b1;
                req_valid_out <= 1'b1;
                state         <= REQ;
              end else begin
                busy_out <= 1'b0;
                done_out <= 1'b1;
                state    <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disparity_search_engine.sv
// Bench for disparity_search_engine: two instances (tie-last / tie-first)
// share one cost-unit model and are checked against a frame-level model.
module tb_disparity_search_engine;

  localparam int IMG_W = 8;
  localparam int IMG_H = 7;
  localparam int BS    = 6;
  localparam int MAXD  = 2;
  localparam int CW    = 16;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int DW    = $clog2(MAXD + 1);
  localparam int AW    = $clog2(IMG_W * IMG_H);

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic [CW-1:0] thresh;
  logic req_ready;
  logic cost_valid;
  logic [CW-1:0] cost;
  logic res_ready;

  logic busy_a, done_a, req_valid_a, res_valid_a, res_conf_a;
  logic [XW-1:0] req_x_a;
  logic [YW-1:0] req_y_a;
  logic [DW-1:0] req_d_a, res_disp_a;
  logic [AW-1:0] res_addr_a;
  logic busy_b, done_b, req_valid_b, res_valid_b, res_conf_b;
  logic [XW-1:0] req_x_b;
  logic [YW-1:0] req_y_b;
  logic [DW-1:0] req_d_b, res_disp_b;
  logic [AW-1:0] res_addr_b;

  always #5 clk = ~clk;

  disparity_search_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(BS),
    .MAX_DISP(MAXD), .COST_W(CW), .TIE_LAST(1)
  ) dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
    .cost_thresh_in(thresh), .busy_out(busy_a), .done_out(done_a),
    .req_valid_out(req_valid_a), .req_ready_in(req_ready),
    .req_x_out(req_x_a), .req_y_out(req_y_a), .req_d_out(req_d_a),
    .cost_valid_in(cost_valid), .cost_in(cost),
    .res_valid_out(res_valid_a), .res_ready_in(res_ready),
    .res_addr_out(res_addr_a), .res_disp_out(res_disp_a),
    .res_conf_out(res_conf_a)
  );

  disparity_search_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(BS),
    .MAX_DISP(MAXD), .COST_W(CW), .TIE_LAST(0)
  ) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
    .cost_thresh_in(thresh), .busy_out(busy_b), .done_out(done_b),
    .req_valid_out(req_valid_b), .req_ready_in(req_ready),
    .req_x_out(req_x_b), .req_y_out(req_y_b), .req_d_out(req_d_b),
    .cost_valid_in(cost_valid), .cost_in(cost),
    .res_valid_out(res_valid_b), .res_ready_in(res_ready),
    .res_addr_out(res_addr_b), .res_disp_out(res_disp_b),
    .res_conf_out(res_conf_b)
  );

  typedef struct {
    int addr;
    int dl;
    int df;
    int cf;
    int cfb;
  } res_t;

  typedef struct {
    int c0, c1, c2;
    int thr;
    int e_last, e_first, e_conf;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cost_tab [IMG_H][IMG_W][MAXD+1];
  int exp_req[$];
  int got_req[$];
  res_t exp_res[$];
  res_t got_res[$];
  int exp_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pk(input int x, input int y, input int d);
    return x * 65536 + y * 256 + d;
  endfunction

  function automatic int look(input int x, input int y, input int d);
    if (x < IMG_W && y < IMG_H && d <= MAXD) return cost_tab[y][x][d];
    return 0;
  endfunction

  task automatic fill_const(input int v);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        for (int d = 0; d <= MAXD; d++) cost_tab[y][x][d] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        for (int d = 0; d <= MAXD; d++)
          cost_tab[y][x][d] = int'($urandom_range(0, 7));
  endtask

  // frame-level expectation: argmin over each pixel's candidate list
  task automatic build_exp(input int thr);
    int dm, mn, lo, hi, c;
    exp_req.delete();
    exp_res.delete();
    exp_cyc = 1;
    for (int yy = 0; yy <= IMG_H - BS; yy++) begin
      for (int xx = 0; xx <= IMG_W - BS; xx++) begin
        dm = (xx < MAXD) ? xx : MAXD;
        mn = 1 << 30;
        lo = 0;
        hi = 0;
        for (int d = 0; d <= dm; d++) begin
          exp_req.push_back(pk(xx, yy, d));
          c = cost_tab[yy][xx][d];
          if (c < mn) begin
            mn = c; lo = d; hi = d;
          end else if (c == mn) begin
            hi = d;
          end
        end
        c = (mn <= thr) ? 1 : 0;
        exp_res.push_back('{yy * IMG_W + xx, hi, lo, c, c});
        exp_cyc += 2 * (dm + 1) + 1;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_a) + int'(busy_b), 0);
    chk({tag, "_done"}, int'(done_a) + int'(done_b), 0);
    chk({tag, "_req_valid"}, int'(req_valid_a) + int'(req_valid_b), 0);
    chk({tag, "_req_x"}, int'(req_x_a) + int'(req_x_b), 0);
    chk({tag, "_req_y"}, int'(req_y_a) + int'(req_y_b), 0);
    chk({tag, "_req_d"}, int'(req_d_a) + int'(req_d_b), 0);
    chk({tag, "_res_valid"}, int'(res_valid_a) + int'(res_valid_b), 0);
    chk({tag, "_res_addr"}, int'(res_addr_a) + int'(res_addr_b), 0);
    chk({tag, "_res_disp"}, int'(res_disp_a) + int'(res_disp_b), 0);
    chk({tag, "_res_conf"}, int'(res_conf_a) + int'(res_conf_b), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int thr, input int lat_max,
                           input int req_st, input int res_st,
                           input bit rnd, input int start_again,
                           input bit chk_cyc);
    int n, wq, wr, lat_c, pc;
    int hx, hy, hd, ha, hdl, hdf, hcf, hcb;
    bit rq_seen, rs_seen, pend, fin;
    build_exp(thr);
    got_req.delete();
    got_res.delete();
    rq_seen = 0; rs_seen = 0; pend = 0; fin = 0;
    wq = 0; wr = 0; lat_c = 0; pc = 0;
    hx = 0; hy = 0; hd = 0; ha = 0; hdl = 0; hdf = 0; hcf = 0; hcb = 0;
    thresh = thr[CW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", int'(busy_a), 1);
    chk("start_req_valid", int'(req_valid_a), 1);
    chk("first_req_xyd", pk(int'(req_x_a), int'(req_y_a), int'(req_d_a)), 0);
    n = 0;
    while (!fin && n < 4000) begin
      n++;
      cost_valid = 1'b0;
      start = (n == start_again);
      if (pend) begin
        if (lat_c == 0) begin
          cost_valid = 1'b1;
          cost = pc[CW-1:0];
          pend = 0;
        end else begin
          lat_c--;
        end
      end
      if (req_valid_a) begin
        if (rq_seen) begin
          chk("req_hold", pk(int'(req_x_a), int'(req_y_a), int'(req_d_a)),
              pk(hx, hy, hd));
        end else begin
          rq_seen = 1;
          hx = int'(req_x_a); hy = int'(req_y_a); hd = int'(req_d_a);
          wq = rnd ? int'($urandom_range(0, 3)) : req_st;
        end
        if (wq == 0) begin
          req_ready = 1'b1;
          rq_seen = 0;
          got_req.push_back(pk(hx, hy, hd));
          pend = 1;
          lat_c = int'($urandom_range(1, lat_max)) - 1;
          pc = look(hx, hy, hd);
        end else begin
          req_ready = 1'b0;
          wq--;
        end
      end else begin
        req_ready = 1'b0;
      end
      if (res_valid_a) begin
        chk("no_req_during_res", int'(req_valid_a), 0);
        if (rs_seen) begin
          chk("res_hold_addr", int'(res_addr_a), ha);
          chk("res_hold_disp", int'(res_disp_a), hdl);
          chk("res_hold_conf", int'(res_conf_a), hcf);
        end else begin
          rs_seen = 1;
          ha = int'(res_addr_a); hdl = int'(res_disp_a);
          hdf = int'(res_disp_b); hcf = int'(res_conf_a);
          hcb = int'(res_conf_b);
          wr = rnd ? int'($urandom_range(0, 3)) : res_st;
        end
        if (wr == 0) begin
          res_ready = 1'b1;
          rs_seen = 0;
          chk("res_valid_b", int'(res_valid_b), 1);
          got_res.push_back('{ha, hdl, hdf, hcf, hcb});
        end else begin
          res_ready = 1'b0;
          wr--;
        end
      end else begin
        res_ready = 1'b0;
      end
      if (done_a) begin
        chk("done_busy", int'(busy_a), 0);
        chk("done_b", int'(done_b), 1);
        if (chk_cyc) chk("frame_cycles", n, exp_cyc);
        fin = 1;
      end
      tick();
    end
    start = 1'b0;
    req_ready = 1'b0;
    res_ready = 1'b0;
    cost_valid = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got no done within %0d cycles", n);
    end
    chk("done_one_pulse", int'(done_a), 0);
    chk("idle_busy", int'(busy_a), 0);
    chk("n_req", got_req.size(), exp_req.size());
    for (int i = 0; i < got_req.size() && i < exp_req.size(); i++)
      chk($sformatf("req[%0d]", i), got_req[i], exp_req[i]);
    chk("n_res", got_res.size(), exp_res.size());
    for (int i = 0; i < got_res.size() && i < exp_res.size(); i++) begin
      chk($sformatf("res_addr[%0d]", i), got_res[i].addr, exp_res[i].addr);
      chk($sformatf("res_dlast[%0d]", i), got_res[i].dl, exp_res[i].dl);
      chk($sformatf("res_dfirst[%0d]", i), got_res[i].df, exp_res[i].df);
      chk($sformatf("res_conf[%0d]", i), got_res[i].cf, exp_res[i].cf);
      chk($sformatf("res_conf_b[%0d]", i), got_res[i].cfb, exp_res[i].cfb);
    end
  endtask

  initial begin
    vec_t vt[5];
    int addr_exp[6];
    int disp_exp[6];
    vt[0] = '{10, 10, 10, 15, 2, 0, 1};
    vt[1] = '{50, 20, 20, 15, 2, 1, 0};
    vt[2] = '{30, 16, 40, 15, 1, 1, 0};
    vt[3] = '{30, 16, 40, 16, 1, 1, 1};
    vt[4] = '{5, 5, 7, 4, 1, 0, 0};
    addr_exp = '{0, 1, 2, 8, 9, 10};
    disp_exp = '{0, 1, 2, 0, 1, 2};

    rst = 1'b0; start = 1'b0; abort = 1'b0; thresh = '0;
    req_ready = 1'b0; cost_valid = 1'b0; cost = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();

    // equal costs, no stalls: request order, addresses, throughput
    fill_const(10);
    run_frame(15, 1, 0, 0, 0, 0, 1);
    chk("t1_n_req", got_req.size(), 12);
    for (int i = 0; i < 6 && i < got_res.size(); i++) begin
      chk($sformatf("t1_addr[%0d]", i), got_res[i].addr, addr_exp[i]);
      chk($sformatf("t1_disp_last[%0d]", i), got_res[i].dl, disp_exp[i]);
      chk($sformatf("t1_disp_first[%0d]", i), got_res[i].df, 0);
    end

    for (int i = 0; i < 5; i++) begin
      fill_const(10);
      cost_tab[0][2][0] = vt[i].c0;
      cost_tab[0][2][1] = vt[i].c1;
      cost_tab[0][2][2] = vt[i].c2;
      run_frame(vt[i].thr, 1, 0, 0, 0, 0, 0);
      if (got_res.size() > 2) begin
        chk($sformatf("vec%0d_last", i), got_res[2].dl, vt[i].e_last);
        chk($sformatf("vec%0d_first", i), got_res[2].df, vt[i].e_first);
        chk($sformatf("vec%0d_conf", i), got_res[2].cf, vt[i].e_conf);
      end
    end

    // request held off 5 cycles, result held off 4 cycles
    fill_rand();
    run_frame(4, 1, 5, 4, 0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_frame(int'($urandom_range(0, 8)), 3, 0, 0, 1, 0, 0);
    end

    // abort while a cost is outstanding, then a stray response
    start = 1'b1;
    tick();
    start = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("abort_pre_busy", int'(busy_a), 1);
    chk("abort_pre_req_valid", int'(req_valid_a), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_req_valid", int'(req_valid_a), 0);
    chk("abort_res_valid", int'(res_valid_a), 0);
    chk("abort_done", int'(done_a), 0);
    cost_valid = 1'b1;
    cost = '0;
    tick();
    cost_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_abort_busy", int'(busy_a), 0);
      chk("post_abort_done", int'(done_a), 0);
      chk("post_abort_req", int'(req_valid_a) + int'(res_valid_a), 0);
      tick();
    end
    fill_rand();
    run_frame(3, 2, 0, 0, 1, 0, 0);

    // async reset while a request at x=1,d=1 is pending
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_ready = req_valid_a;
      res_ready = res_valid_a;
      cost_valid = busy_a & ~req_valid_a & ~res_valid_a;
      cost = 16'd3;
      tick();
    end
    req_ready = 1'b0;
    res_ready = 1'b0;
    cost_valid = 1'b0;
    chk("pre_rst_req", pk(int'(req_x_a), int'(req_y_a), int'(req_d_a)),
        pk(1, 0, 1));
    chk("pre_rst_valid", int'(req_valid_a), 1);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    fill_rand();
    run_frame(5, 2, 0, 0, 1, 9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
